// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and default widths for the MEM->WB stage register
//
// Contents:
//   state_t        occupancy of the stage (EMPTY / ONE / TWO)
//   CTRL_*         bit positions inside the control field
//   DEF_*          default widths used by the stage register parameters
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int CTRL_REGWRITE   = 0;
  localparam int CTRL_MEMTOREG   = 1;
  localparam int CTRL_PCSRC      = 2;
  localparam int CTRL_MVALID     = 3;
  localparam int CTRL_FLOATSTART = 4;

  localparam int DEF_DATA_W = 104;
  localparam int DEF_CTRL_W = 5;
  localparam int DEF_RA_W   = 4;
  localparam int DEF_NADDR  = 2;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-high reset, clears the count
//   inc    count one this cycle
//   cnt    current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_wb_stage_reg.sv
// rtl/mem_wb_stage_reg.sv - MEM->WB pipeline register with valid/ready skid buffer and flush
//
// A main register drives the WB outputs; a skid register catches the one
// entry that may arrive while WB stalls, so in_ready can be a pure register.
// Optional feature macro: MEM_WB_PERF_CNT_EN adds stall_cnt / flush_cnt.
//
// Ports:
//   CLK, RESET              clock, asynchronous active-high reset
//   in_valid/in_ready       MEM-side handshake (in_ready registered, = !skid valid)
//   in_data/in_ctrl/in_addr entry presented by MEM
//   flush                   synchronous kill of every held entry
//   out_valid/out_ready     WB-side handshake
//   out_data/out_ctrl/out_addr  entry presented to WB (out_ctrl is 0 on a bubble)
//   stall_cnt, flush_cnt    perf counters (only with MEM_WB_PERF_CNT_EN)
module mem_wb_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int RA_W   = DEF_RA_W,
  parameter int NADDR  = DEF_NADDR
`ifdef MEM_WB_PERF_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [RA_W*NADDR-1:0] in_addr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [RA_W*NADDR-1:0] out_addr
`ifdef MEM_WB_PERF_CNT_EN
  , output logic [CNT_W-1:0]    stall_cnt
  , output logic [CNT_W-1:0]    flush_cnt
`endif
);

  localparam int ADDR_W = RA_W * NADDR;

  state_t              state;
  logic [DATA_W-1:0]   main_data;
  logic [CTRL_W-1:0]   main_ctrl;
  logic [ADDR_W-1:0]   main_addr;
  logic [DATA_W-1:0]   skid_data;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [ADDR_W-1:0]   skid_addr;

  logic accept;
  logic drain;

  // Flush wins over a same-cycle input, so the accept is suppressed here.
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = out_valid && out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  assign out_addr  = main_addr;
  // main_ctrl is already cleared whenever the stage empties; the gate keeps
  // a RegWrite from ever reaching WB on a bubble regardless.
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      main_data <= '0;
      main_ctrl <= '0;
      main_addr <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      skid_addr <= '0;
    end else if (flush) begin
      // Payload is left in place; only valids and control are killed.
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_ONE;
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            main_addr <= in_addr;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            main_addr <= in_addr;
          end else if (accept) begin
            state     <= ST_TWO;
            in_ready  <= 1'b0;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            skid_addr <= in_addr;
          end else if (drain) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state     <= ST_ONE;
            in_ready  <= 1'b1;
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            main_addr <= skid_addr;
            skid_ctrl <= '0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          main_ctrl <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef MEM_WB_PERF_CNT_EN
  logic stall_inc;
  logic kill_inc;

  assign stall_inc = out_valid && !out_ready;
  // In ONE a same-cycle drain means WB took the entry, so nothing is killed;
  // in TWO the skid entry is always lost.
  assign kill_inc  = flush && ((state == ST_TWO) || ((state == ST_ONE) && !out_ready));

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (kill_inc),
    .cnt   (flush_cnt)
  );
`endif

endmodule

// File: doc/mem_wb_stage_reg.md
Name: mem_wb_stage_reg

Overview:
Parametrised successor to the fixed MEM->WB pipeline latch. Carries a configurable-width data payload and a separate control field between the memory and writeback stages. Adds a valid/ready handshake backed by a 2-entry skid buffer, so writeback back-pressure (for example a multi-cycle float writeback) stalls without dropping results. Adds flush that converts in-flight entries to bubbles.

Parameters:
DATA_W, 104, payload width (ReadData, ALUOut, WResult packed; never cleared by flush)
CTRL_W, 5, control width (RegWrite, MemtoReg, PCSrc, Mvalid, Float_start); forced to 0 on reset, flush and bubble
RA_W, 4, register-address width per address field
NADDR, 2, number of address fields (WA3, MWA3); bus width RA_W*NADDR
CNT_W, 16, perf counter width (used only with the optional feature)

Ports:
CLK  in  1  rising-edge clock
RESET  in  1  asynchronous, active-high reset
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  stage can accept an entry; registered, equals !skid_valid
in_data  in  DATA_W  payload
in_ctrl  in  CTRL_W  control bits
in_addr  in  RA_W*NADDR  write-address fields
flush  in  1  synchronous kill of all held entries
out_valid  out  1  WB entry valid
out_ready  in  1  WB consumes the entry this cycle
out_data  out  DATA_W  payload
out_ctrl  out  CTRL_W  control bits; 0 whenever out_valid=0
out_addr  out  RA_W*NADDR  write addresses

Behaviour:
- Reset (asynchronous, active-high, any cycle including mid-stall): state EMPTY; main and skid valid bits=0; out_ctrl=0; out_data=0; out_addr=0; in_ready=1 once RESET deasserts.
- Storage: a main register drives the outputs; a skid register holds one spare entry. States: EMPTY (none valid), ONE (main valid), TWO (main+skid valid).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1 when main is empty or being drained in cycle N.
- EMPTY: on accept -> ONE, main loads the input.
- ONE:
  - accept && drain -> ONE, main reloads the input.
  - accept && !drain -> TWO, skid loads the input.
  - drain only -> EMPTY.
  - neither -> hold.
- TWO: in_ready=0, so no accept is possible. Drain -> ONE, main <- skid. No drain -> hold every bit stable.
- Order: strictly FIFO; entries are never reordered or duplicated.
- Bubble: when out_valid=0, out_ctrl is driven to 0 so WB never sees a RegWrite from a non-entry. out_data and out_addr may hold stale values.
- Flush: next state EMPTY; both valid bits and main ctrl cleared; in_ready=1 next cycle.
  - flush && in_valid in the same cycle: flush wins and the input is dropped.
  - flush && drain in the same cycle: the drain counts (WB has already sampled it); no entry remains.
- Width: all registers are exactly the parameter widths; no truncation.

Optional Feature:
MEM_WB_PERF_CNT_EN
- Defined: adds outputs stall_cnt [CNT_W-1:0] and flush_cnt [CNT_W-1:0].
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - flush_cnt increments each cycle flush kills at least one valid entry.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg: state enum (ST_EMPTY=0, ST_ONE=1, ST_TWO=2); CTRL bit indices (CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_PCSRC=2, CTRL_MVALID=3, CTRL_FLOATSTART=4); default widths.
- One natural sub-module: sat_counter (CNT_W, inc, RESET), instantiated twice under the macro.

Test Plan:
- Reset mid-stream: state TWO, assert RESET asynchronously between edges -> out_valid=0, out_ctrl=0 immediately; in_ready=1 after release.
- Pass-through: out_ready=1, 4 back-to-back entries with in_data=1..4, in_ctrl=5'b00001 -> out_data=1..4 on consecutive cycles, each 1 cycle after its accept, in_ready stays 1.
- Back-pressure: out_ready=0, send A=0x11 and B=0x22 -> in_ready=0 after B, out_data=0x11 held stable. Raise out_ready -> outputs 0x11 then 0x22, then out_valid=0.
- Flush with input: state TWO, flush=1 with in_valid=1 (data 0x33) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x33 never appears.
- Flush with drain: state ONE, out_ready=1 and flush=1 same cycle -> entry counted as consumed, state EMPTY, no duplicate output.
- With MEM_WB_PERF_CNT_EN and CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); one killing flush -> flush_cnt=1.
